// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge
//   SPI-slave (mode 0, MSB first) front end that turns byte-framed SPI
//   transactions into single-byte read/write requests on a valid/ready bus.
//   SCK, MOSI and SS_n are oversampled in the clk domain; SCK is never a clock.
//   Frame: CMD (bit7 = write), ADDR_HI, ADDR_LO, then DATA bytes.
//
// Configuration macro: SPI_BRIDGE_AUTOINC_EN
//   defined   : address increments (mod 2^16) after every data handshake
//   undefined : address fixed for the whole transaction (FIFO-port mode)
//
// Ports
//   clk, rst_n          system clock, async active-low reset
//   spi_ss_n/sck/mosi   raw SPI pins (asynchronous to clk)
//   spi_miso            SPI data out
//   bus_valid/write/addr/wdata, bus_ready, bus_rdata   byte request bus
//   busy                synchronized SS asserted
//   overrun             1-cycle pulse: dropped byte or late read response
module spi_bus_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_ss_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ready,
    input  logic [7:0]  bus_rdata,
    output logic        busy,
    output logic        overrun
);

`ifdef SPI_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR_HI, ADDR_LO, DATA} state_e;
    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ss_sync_q;
    logic        sck_prev_q;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [6:0]  rx_q, rx_d;          // the 8th bit comes straight from mosi
    logic [7:0]  tx_q, tx_d;
    logic        skip_q, skip_d;      // suppress the first fall after a byte boundary
    logic        wr_mode_q, wr_mode_d;
    logic [15:0] cur_addr_q, cur_addr_d;
    logic        valid_q, valid_d, write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        own_q, own_d;        // outstanding request belongs to the live transaction
    logic        win_q, win_d;        // read response may still load tx
    logic        dfr_q, dfr_d, dfr_wr_q, dfr_wr_d;
    logic [7:0]  dfr_data_q, dfr_data_d;
    logic        overrun_q, overrun_d;

    logic sck_s, mosi_s, ss_s, rise, fall, active, leaving, byte_done;
    logic hs, own_hs, bus_free, dfr_go, want, want_wr, win_ok;
    logic [7:0]  rx_byte;
    logic [15:0] addr_eff, want_addr;

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign rise      = sck_s & ~sck_prev_q;
    assign fall      = ~sck_s & sck_prev_q;
    assign active    = (state_q != IDLE) & ~ss_s;
    assign leaving   = (state_q != IDLE) & ss_s;
    assign byte_done = active & rise & (bitcnt_q == 3'd7);
    assign rx_byte   = {rx_q, mosi_s};

    assign hs       = valid_q & bus_ready;
    assign own_hs   = hs & own_q;
    assign bus_free = ~valid_q | bus_ready;
    // A request deferred behind the previous transaction's stall goes out
    // as soon as the bus is empty.
    assign dfr_go   = dfr_q & ~valid_q;
    // Handshake retires before a same-cycle byte completion, so the new
    // request already sees the incremented address.
    assign addr_eff = (AUTOINC && own_hs) ? addr_q + 16'd1 : cur_addr_q;
    assign want     = byte_done & ((state_q == ADDR_LO & ~wr_mode_q) | (state_q == DATA));
    assign want_wr  = (state_q == DATA) & wr_mode_q;
    assign want_addr = (state_q == ADDR_LO) ? {cur_addr_q[15:8], rx_byte} : addr_eff;
    assign win_ok   = win_q & ~(active & rise & (bitcnt_q == 3'd0));

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        skip_d     = skip_q;
        wr_mode_d  = wr_mode_q;
        cur_addr_d = cur_addr_q;
        valid_d    = valid_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        own_d      = own_q;
        win_d      = win_q;
        dfr_d      = dfr_q;
        dfr_wr_d   = dfr_wr_q;
        dfr_data_d = dfr_data_q;
        overrun_d  = 1'b0;

        if (state_q == IDLE) begin
            if (!ss_s) state_d = CMD;
        end else if (ss_s) begin
            state_d = IDLE;
        end else if (byte_done) begin
            case (state_q)
                CMD:     state_d = ADDR_HI;
                ADDR_HI: state_d = ADDR_LO;
                default: state_d = DATA;
            endcase
        end

        // Bit/byte shifting
        if (state_q == IDLE) begin
            bitcnt_d = 3'd0;
            rx_d     = 7'd0;
            tx_d     = 8'h00;
            skip_d   = 1'b0;
        end else if (active) begin
            if (rise) begin
                bitcnt_d = bitcnt_q + 3'd1;
                rx_d     = rx_byte[6:0];
                if (bitcnt_q == 3'd0) win_d = 1'b0;
            end
            if (fall) begin
                if (skip_q) skip_d = 1'b0;
                else        tx_d   = {tx_q[6:0], 1'b0};
            end
            if (byte_done) begin
                tx_d   = 8'h00;
                skip_d = 1'b1;
            end
        end

        // Address register: byte loads win over the increment
        if (own_hs && AUTOINC) cur_addr_d = addr_q + 16'd1;
        if (byte_done) begin
            case (state_q)
                CMD:     wr_mode_d        = rx_byte[7];
                ADDR_HI: cur_addr_d[15:8] = rx_byte;
                ADDR_LO: cur_addr_d[7:0]  = rx_byte;
                default: ;
            endcase
        end

        // Handshake retirement and read response
        if (hs) begin
            valid_d = 1'b0;
            own_d   = 1'b0;
        end
        if (own_hs && !write_q) begin
            if (win_ok) tx_d      = bus_rdata;
            else        overrun_d = 1'b1;
            win_d = 1'b0;
        end

        if (dfr_go) begin
            valid_d = 1'b1;
            write_d = dfr_wr_q;
            addr_d  = cur_addr_q;
            if (dfr_wr_q) wdata_d = dfr_data_q;
            own_d   = active;
            dfr_d   = 1'b0;
        end

        if (want) begin
            if (bus_free && !dfr_go) begin
                valid_d = 1'b1;
                write_d = want_wr;
                addr_d  = want_addr;
                if (want_wr) wdata_d = rx_byte;
                else         win_d   = 1'b1;
                own_d   = 1'b1;
            end else if (valid_q && !own_q && !dfr_q) begin
                // Stalled request from an earlier transaction: queue behind it
                dfr_d      = 1'b1;
                dfr_wr_d   = want_wr;
                dfr_data_d = rx_byte;
                if (!want_wr) win_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (leaving) begin
            own_d = 1'b0;
            win_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
            sck_prev_q  <= sck_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt_q   <= 3'd0;
            rx_q       <= 7'd0;
            tx_q       <= 8'h00;
            skip_q     <= 1'b0;
            wr_mode_q  <= 1'b0;
            cur_addr_q <= 16'h0000;
            valid_q    <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 8'h00;
            own_q      <= 1'b0;
            win_q      <= 1'b0;
            dfr_q      <= 1'b0;
            dfr_wr_q   <= 1'b0;
            dfr_data_q <= 8'h00;
            overrun_q  <= 1'b0;
        end else begin
            bitcnt_q   <= bitcnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            skip_q     <= skip_d;
            wr_mode_q  <= wr_mode_d;
            cur_addr_q <= cur_addr_d;
            valid_q    <= valid_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            own_q      <= own_d;
            win_q      <= win_d;
            dfr_q      <= dfr_d;
            dfr_wr_q   <= dfr_wr_d;
            dfr_data_q <= dfr_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign spi_miso  = (state_q == DATA) & ~ss_s & tx_q[7];
    assign bus_valid = valid_q;
    assign bus_write = write_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign busy      = ~ss_s;
    assign overrun   = overrun_q;

endmodule

// File: doc/spi_bus_bridge.md
# spi_bus_bridge

SPI-slave front end for the Levenshtein core. It takes the raw SS/SCK/MOSI pins from `ui_in[4..6]` and drives MISO on `uo_out[7]`. It decodes byte-framed SPI transactions into single-byte read/write requests on a valid/ready bus to the core's memory. All logic runs in the `clk` domain; SCK is oversampled, never used as a clock.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers for sck/mosi/ss_n (≥2).
- `clk` in 1: system clock (PLL output); must be ≥8× SCK frequency.
- `rst_n` in 1: reset, asynchronous assert, active-low; one clock domain `clk`.
- `spi_ss_n` in 1: raw chip select, active-low, asynchronous to `clk`.
- `spi_sck` in 1: raw SPI clock, mode 0 (CPOL=0, CPHA=0).
- `spi_mosi` in 1: raw SPI data in, MSB first.
- `spi_miso` out 1: SPI data out, MSB first.
- `bus_valid` out 1: request valid; held until `bus_ready`.
- `bus_write` out 1: 1 = write, 0 = read.
- `bus_addr` out 16: byte address.
- `bus_wdata` out 8: write data.
- `bus_ready` in 1: handshake completes on the cycle where `bus_valid & bus_ready`.
- `bus_rdata` in 8: read data, sampled on a read handshake cycle.
- `busy` out 1: synchronized SS is asserted.
- `overrun` out 1: one-cycle pulse on a dropped byte or a late read response.

## Operation
- Synchronizers: sck, mosi and ss_n each pass through `SYNC_STAGES` flops. The registered sck gives `rise` and `fall` strobes. mosi uses the same delay, so it is sampled on `rise`.
- FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, DATA. A 3-bit bit counter and an 8-bit rx shift register advance on each `rise`. A byte completes on the 8th `rise`.
- IDLE → CMD when synchronized ss_n falls. The bit counter and rx register clear.
- CMD byte: bit7 = 1 means write, 0 means read. Bits 6:0 are ignored. Then → ADDR_HI.
- ADDR_HI → ADDR_LO → DATA. The address register loads MSB byte then LSB byte.
- On ADDR_LO completion in read mode, a read request issues at the loaded address.
- DATA, write mode:
  - Each completed byte issues a write of that byte to the current address.
  - If the previous request is still pending, the byte is dropped and `overrun` pulses.
- DATA, read mode:
  - Each completed byte issues the next read. This is a prefetch, and it issues after the address update.
  - On the read handshake, the tx register loads `bus_rdata`.
- Address update: the address increments (mod 2^16) after each data-byte handshake (see Configuration).
- tx shift register:
  - `spi_miso` = tx[7].
  - tx shifts left (fill 0) on each `fall` except the first `fall` after a byte boundary.
  - tx clears at byte boundary unless a response loads it.
  - If a read response arrives after the first `rise` of the byte it serves, it is discarded: `overrun` pulses and that byte returns 0x00.
- SS deassert in any state:
  - FSM returns to IDLE the cycle after synchronized ss_n rises.
  - A partial byte is discarded with no request issued.
  - A pending `bus_valid` still holds until its handshake. The next transaction's first request waits behind it.
- `spi_miso` = 0 while ss_n is high and in CMD/ADDR states.
- Simultaneous handshake and byte completion: the handshake retires first, so the new request is accepted with no overrun.

## Timing
- Reset values: `spi_miso`=0, `bus_valid`=0, `bus_write`=0, `bus_addr`=0x0000, `bus_wdata`=0x00, `busy`=0, `overrun`=0.
- FSM in IDLE; all counters and shift registers 0.
- Pin-to-strobe latency: `SYNC_STAGES`+1 clk.
- `bus_valid` rises 1 clk after the `rise` strobe of the byte's final bit.
- `spi_miso` updates 1 clk after the `fall` strobe, i.e. `SYNC_STAGES`+2 clk after the pin edge.
- Read budget: the response must arrive within roughly 4 clk of the last `rise` of the preceding byte at an 8× clk/SCK ratio.
- Reset mid-transaction: all outputs drop asynchronously and the in-flight request is abandoned. The master must restart the transaction after SS high.

## Configuration
- `SPI_BRIDGE_AUTOINC_EN` defined: `bus_addr` increments by 1 after every DATA-phase handshake, wrapping 0xFFFF→0x0000.
- `SPI_BRIDGE_AUTOINC_EN` undefined: the address stays fixed for the whole transaction (FIFO-port mode). Every data byte reads or writes the same address.

## Test plan
- Write burst: with AUTOINC, send 0x80 0x12 0x34 0xAB 0xCD, `bus_ready`=1 → writes (0x1234,0xAB) then (0x1235,0xCD); `overrun` stays 0.
- Read burst: with AUTOINC, send 0x00 0x00 0x10 + 2 dummy bytes, memory [0x0010]=0x5A, [0x0011]=0xC3 → MISO shifts 0x5A then 0xC3. Reads issue at 0x0010, 0x0011, 0x0012.
- Abort: drop SS after 4 bits of ADDR_LO → no bus request, `busy` falls. The next write 0x80 0x00 0x01 0x77 lands at 0x0001.
- Stall: hold `bus_ready`=0 across two write data bytes → the first is held on the bus, the second is dropped, `overrun` pulses exactly once.
- Address wrap: AUTOINC, write at 0xFFFF with 2 bytes → addresses 0xFFFF then 0x0000.
- Async reset with `bus_valid`=1 → all outputs at reset values in the same cycle. Without the macro, a 3-byte write to 0x0040 produces three writes to 0x0040.
